sha3_absorb_reader: RTL and testbench
=====================================

// Module: sha3_absorb_reader
// PURPOSE
//  Reader end of the 64-bit message syn_fifo: pops message lanes, appends SHA3 padding, and emits rate-sized blocks to the Keccak absorb stage.
//  Sits between the message-input FIFO and the Keccak permutation core.
//  Message length is given in whole 64-bit lanes; padding is lane-granular.
// PARAMETERS
//  LANE_W      64   lane / FIFO data width
//  RATE_LANES  17   lanes per rate block (17 = SHA3-256, 1088 bits)
//  LEN_W       16   width of msg_lanes
// PORTS
//  clk           in   1                   rising-edge clock
//  rst_n         in   1                   async active-low reset
//  start         in   1                   pulse: begin a message (accepted only when !busy)
//  msg_lanes     in   LEN_W               message length in lanes, sampled on accepted start
//  busy          out  1                   high from accepted start through final block handoff
//  done          out  1                   1-cycle pulse when the final block is accepted
//  fifo_rd_en    out  1                   pop request to syn_fifo
//  fifo_rd_data  in   LANE_W              FIFO read data, valid the cycle after fifo_rd_en
//  fifo_empty    in   1                   FIFO empty flag
//  blk_valid     out  1                   rate block available
//  blk_ready     in   1                   Keccak stage accepts block
//  blk_data      out  RATE_LANES*LANE_W   lane i at bits [i*64 +: 64]
//  blk_last      out  1                   marks final block of message, qualified by blk_valid
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; counters and block register cleared. Reset is honoured mid-message, with no partial output.
//  FSM IDLE -> FILL (start accepted) -> PAD -> OUT -> FILL | IDLE.
//  IDLE: start ignored while busy. On start, latch remaining = msg_lanes.
//  FILL: fifo_rd_en = !fifo_empty && issued < need; need = min(remaining, RATE_LANES).
//   Capture on the cycle after each pop (rd_pend_q); write lane[cap_idx], cap_idx++.
//   Throughput is 1 lane/clk while the FIFO is non-empty. Empty stalls without a pop or a capture.
//   fifo_rd_en never goes high in PAD, OUT or IDLE, and never exceeds need.
//  FILL -> PAD when captured == need; remaining -= need.
//  PAD (1 clk): if need < RATE_LANES (or remaining was 0), the block is final:
//   lane[need] |= 64'h06, lane[RATE_LANES-1] |= 64'h8000_0000_0000_0000, other unused lanes are 0.
//   need == RATE_LANES-1 gives last lane 64'h8000_0000_0000_0006.
//   need == RATE_LANES is a full data block, not final; a pad-only block follows when remaining hits 0.
//  OUT: blk_valid=1; blk_data and blk_last are held stable until blk_valid && blk_ready.
//   On handshake: if final, pulse done and go to IDLE with busy=0; else clear lanes and go to FILL.
//  msg_lanes=0 gives exactly one pad-only final block.
//  Block count = floor(msg_lanes/RATE_LANES)+1.
//  Arithmetic: remaining/need are LEN_W wide and never underflow; cap_idx is $clog2(RATE_LANES) wide.
// STRUCTURE
//  sha3_pkg: LANE_W, PAD_DOMAIN=64'h06, PAD_END=64'h8000_0000_0000_0000, rd_state_e enum.
//  Single module, no sub-module; lane register array with write-enable per lane index.
// TESTING
//  T1 msg_lanes=0 -> one block: lane0=0x06, lane16=0x8000..0000, rest 0, blk_last=1, done 1 clk.
//  T2 msg_lanes=3, FIFO {A5A5..A5, 1234567890ABCDEF, DEADBEEF..} -> lanes0-2 = data, lane3=0x06, lane16=0x80..00.
//  T3 msg_lanes=17 -> blk1 all data, blk_last=0; blk2 pad-only, blk_last=1; exactly 17 pops.
//  T4 msg_lanes=16 -> single block, lane16=64'h8000_0000_0000_0006.
//  T5 blk_ready low 5 clk + FIFO empty mid-fill -> blk_data stable, no pops while empty/OUT.
//  T6 rst_n low during FILL -> all outputs 0 async; next start (msg_lanes=1) gives correct block.

Source files
------------

// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA3 message absorb path.
// Padding constants are lane-granular for byte-aligned SHA3 domain separation.
package sha3_pkg;
   localparam int LANE_W = 64;
   localparam logic [63:0] PAD_DOMAIN = 64'h06;
   localparam logic [63:0] PAD_END    = 64'h8000_0000_0000_0000;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_FILL,
      RD_PAD,
      RD_OUT
   } rd_state_e;
endpackage

// File: rtl/sha3_absorb_reader.sv
// Reader end of the message FIFO: pops lanes, applies SHA3 padding and hands
// rate-sized blocks to the Keccak absorb stage.
module sha3_absorb_reader #(
   parameter int LANE_W     = 64,
   parameter int RATE_LANES = 17,
   parameter int LEN_W      = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [LEN_W-1:0]             msg_lanes,
   output logic                         busy,
   output logic                         done,
   output logic                         fifo_rd_en,
   input  logic [LANE_W-1:0]            fifo_rd_data,
   input  logic                         fifo_empty,
   output logic                         blk_valid,
   input  logic                         blk_ready,
   output logic [RATE_LANES*LANE_W-1:0] blk_data,
   output logic                         blk_last
);
   import sha3_pkg::*;

   localparam int IDX_W = $clog2(RATE_LANES);

   rd_state_e         state;
   logic [LEN_W-1:0]  remaining;
   logic [LEN_W-1:0]  need;
   logic [IDX_W-1:0]  issued;
   logic [IDX_W-1:0]  cap_idx;
   logic              rd_pend_q;
   logic [LANE_W-1:0] lane_q   [RATE_LANES];
   logic [LANE_W-1:0] pad_lane [RATE_LANES];
   logic              is_final;

   function automatic logic [LEN_W-1:0] block_need(input logic [LEN_W-1:0] r);
      return (r > LEN_W'(RATE_LANES)) ? LEN_W'(RATE_LANES) : r;
   endfunction

   assign fifo_rd_en = (state == RD_FILL) && !fifo_empty && (LEN_W'(issued) < need);
   assign is_final   = (need < LEN_W'(RATE_LANES));

   // Padded view of the lane register; both pad bytes may land in the last lane.
   always_comb begin
      for (int i = 0; i < RATE_LANES; i++) begin
         pad_lane[i] = lane_q[i];
         if (LEN_W'(i) == need)
            pad_lane[i] = pad_lane[i] | LANE_W'(PAD_DOMAIN);
         if (i == RATE_LANES - 1)
            pad_lane[i] = pad_lane[i] | LANE_W'(PAD_END);
      end
   end

   always_comb begin
      for (int i = 0; i < RATE_LANES; i++)
         blk_data[i*LANE_W +: LANE_W] = lane_q[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RD_IDLE;
         remaining <= '0;
         need      <= '0;
         issued    <= '0;
         cap_idx   <= '0;
         rd_pend_q <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         blk_valid <= 1'b0;
         blk_last  <= 1'b0;
         for (int i = 0; i < RATE_LANES; i++)
            lane_q[i] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            RD_IDLE: begin
               if (start) begin
                  remaining <= msg_lanes;
                  need      <= block_need(msg_lanes);
                  issued    <= '0;
                  cap_idx   <= '0;
                  busy      <= 1'b1;
                  state     <= RD_FILL;
               end
            end
            RD_FILL: begin
               rd_pend_q <= fifo_rd_en;
               if (fifo_rd_en)
                  issued <= issued + IDX_W'(1);
               // FIFO data arrives one cycle after the pop
               if (rd_pend_q) begin
                  for (int i = 0; i < RATE_LANES; i++)
                     if (cap_idx == IDX_W'(i))
                        lane_q[i] <= fifo_rd_data;
                  cap_idx <= cap_idx + IDX_W'(1);
               end
               if (!rd_pend_q && (LEN_W'(cap_idx) == need))
                  state <= RD_PAD;
            end
            RD_PAD: begin
               remaining <= remaining - need;
               if (is_final)
                  for (int i = 0; i < RATE_LANES; i++)
                     lane_q[i] <= pad_lane[i];
               blk_valid <= 1'b1;
               blk_last  <= is_final;
               state     <= RD_OUT;
            end
            RD_OUT: begin
               if (blk_ready) begin
                  blk_valid <= 1'b0;
                  blk_last  <= 1'b0;
                  issued    <= '0;
                  cap_idx   <= '0;
                  for (int i = 0; i < RATE_LANES; i++)
                     lane_q[i] <= '0;
                  if (blk_last) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= RD_IDLE;
                  end else begin
                     need  <= block_need(remaining);
                     state <= RD_FILL;
                  end
               end
            end
            default: state <= RD_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sha3_absorb_reader.sv
// Directed bench for sha3_absorb_reader: FIFO model, block collector, vector
// table plus hand-written backpressure, empty-stall and reset sequences.
module tb_sha3_absorb_reader;
   localparam int RL = 17;
   localparam int LW = 64;
   localparam logic [63:0] PEND = 64'h8000_0000_0000_0000;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [15:0]       msg_lanes;
   logic              busy, done, fifo_rd_en, fifo_empty;
   logic [63:0]       fifo_rd_data = '0;
   logic              blk_valid, blk_ready, blk_last;
   logic [RL*LW-1:0]  blk_data;

   sha3_absorb_reader #(.LANE_W(LW), .RATE_LANES(RL), .LEN_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .msg_lanes(msg_lanes),
      .busy(busy), .done(done), .fifo_rd_en(fifo_rd_en),
      .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
      .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
      .blk_last(blk_last)
   );

   always #5 clk = ~clk;

   // FIFO model: data appears the cycle after a pop
   logic [63:0] fmem [0:255];
   int wr_p = 0, rd_p = 0, pops = 0, bad_rd = 0;
   assign fifo_empty = (rd_p == wr_p);

   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_rd_data <= fmem[rd_p[7:0]];
         rd_p <= rd_p + 1;
         pops <= pops + 1;
         if (fifo_empty || blk_valid) bad_rd <= bad_rd + 1;
      end
   end

   logic [RL*LW-1:0] cap_blk  [0:63];
   logic             cap_last [0:63];
   int nblk = 0, ndone = 0;

   always @(posedge clk) begin
      if (blk_valid && blk_ready) begin
         cap_blk[nblk[5:0]]  <= blk_data;
         cap_last[nblk[5:0]] <= blk_last;
         nblk <= nblk + 1;
      end
      if (done) ndone <= ndone + 1;
   end

   int checks = 0, errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] dval(input int k);
      logic [31:0] kk;
      kk = k;
      return {16'hC0DE, kk[15:0], kk * 32'h9E37_79B9};
   endfunction

   // Reference lane value for block b, lane j of a message of len lanes filled with dval()
   function automatic logic [63:0] exp_lane(input int len, input int b, input int j);
      logic [63:0] v;
      int idx;
      idx = b * RL + j;
      v = '0;
      if (idx < len) return dval(idx);
      if (b == len / RL && j == len - b * RL) v = v | 64'h06;
      if (b == len / RL && j == RL - 1) v = v | PEND;
      return v;
   endfunction

   function automatic logic [63:0] cap_lane(input int bi, input int j);
      logic [RL*LW-1:0] blk;
      blk = cap_blk[bi % 64];
      return blk[j*LW +: LW];
   endfunction

   task automatic push(input logic [63:0] d);
      fmem[wr_p[7:0]] = d;
      wr_p++;
   endtask

   task automatic start_msg(input int len, input string tag);
      @(negedge clk);
      msg_lanes = 16'(len);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, ".busy_after_start"}, busy, 1'b1);
   endtask

   task automatic wait_done(input string tag);
      int cyc;
      cyc = 0;
      while (done !== 1'b1 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, ".done_seen"}, (cyc < 3000), 1'b1);
      @(negedge clk);
      check({tag, ".busy_clear"}, busy, 1'b0);
      check({tag, ".done_pulse"}, done, 1'b0);
   endtask

   // Full message using dval() data, checked lane-by-lane against the reference model
   task automatic run_msg(input int len, input int exp_blocks, input logic [63:0] exp_l16,
                          input string tag);
      int b0, p0, d0;
      for (int k = 0; k < len; k++) push(dval(k));
      b0 = nblk; p0 = pops; d0 = ndone;
      start_msg(len, tag);
      wait_done(tag);
      check({tag, ".blocks"}, nblk - b0, exp_blocks);
      check({tag, ".pops"}, pops - p0, len);
      check({tag, ".done_count"}, ndone - d0, 1);
      for (int b = 0; b < exp_blocks; b++) begin
         check($sformatf("%s.last_b%0d", tag, b), cap_last[(b0 + b) % 64], (b == exp_blocks - 1));
         for (int j = 0; j < RL; j++)
            check($sformatf("%s.b%0d_l%0d", tag, b, j), cap_lane(b0 + b, j), exp_lane(len, b, j));
      end
      check({tag, ".final_l16"}, cap_lane(b0 + exp_blocks - 1, RL - 1), exp_l16);
   endtask

   typedef struct {
      int          len;
      int          exp_blocks;
      logic [63:0] exp_l16;
   } vec_t;

   vec_t vt [6];

   initial begin
      logic [RL*LW-1:0] snap;
      int b0, p0, cyc;

      vt[0] = '{0,  1, 64'h8000_0000_0000_0000};
      vt[1] = '{3,  1, 64'h8000_0000_0000_0000};
      vt[2] = '{16, 1, 64'h8000_0000_0000_0006};
      vt[3] = '{17, 2, 64'h8000_0000_0000_0000};
      vt[4] = '{18, 2, 64'h8000_0000_0000_0000};
      vt[5] = '{34, 3, 64'h8000_0000_0000_0000};

      rst_n = 1'b0; start = 1'b0; msg_lanes = '0; blk_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst.busy", busy, 1'b0);
      check("rst.done", done, 1'b0);
      check("rst.rd_en", fifo_rd_en, 1'b0);
      check("rst.blk_valid", blk_valid, 1'b0);
      check("rst.blk_last", blk_last, 1'b0);
      check("rst.blk_data", (blk_data == '0), 1'b1);

      for (int v = 0; v < 6; v++)
         run_msg(vt[v].len, vt[v].exp_blocks, vt[v].exp_l16, $sformatf("tab%0d", vt[v].len));

      // Literal data lanes followed by lane-granular padding
      push(64'hA5A5_A5A5_A5A5_A5A5);
      push(64'h1234_5678_90AB_CDEF);
      push(64'hDEAD_BEEF_DEAD_BEEF);
      b0 = nblk;
      start_msg(3, "t2");
      wait_done("t2");
      check("t2.l0", cap_lane(b0, 0), 64'hA5A5_A5A5_A5A5_A5A5);
      check("t2.l1", cap_lane(b0, 1), 64'h1234_5678_90AB_CDEF);
      check("t2.l2", cap_lane(b0, 2), 64'hDEAD_BEEF_DEAD_BEEF);
      check("t2.l3", cap_lane(b0, 3), 64'h06);
      check("t2.l4", cap_lane(b0, 4), 64'h0);
      check("t2.l16", cap_lane(b0, 16), 64'h8000_0000_0000_0000);
      check("t2.last", cap_last[b0 % 64], 1'b1);

      // FIFO runs empty mid-fill, then the block is back-pressured
      blk_ready = 1'b0;
      push(dval(0)); push(dval(1));
      b0 = nblk; p0 = pops;
      start_msg(5, "t5");
      repeat (5) @(negedge clk);
      for (int c = 0; c < 3; c++) begin
         check("t5.no_pop_empty", fifo_rd_en, 1'b0);
         check("t5.stall_busy", busy, 1'b1);
         check("t5.stall_no_valid", blk_valid, 1'b0);
         @(negedge clk);
      end
      check("t5.pops_before_refill", pops - p0, 2);
      push(dval(2)); push(dval(3)); push(dval(4));
      cyc = 0;
      while (blk_valid !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("t5.valid_seen", (cyc < 100), 1'b1);
      snap = blk_data;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("t5.data_stable", (blk_data === snap), 1'b1);
         check("t5.valid_held", blk_valid, 1'b1);
         check("t5.last_held", blk_last, 1'b1);
         check("t5.no_pop_out", fifo_rd_en, 1'b0);
      end
      blk_ready = 1'b1;
      wait_done("t5");
      check("t5.pops", pops - p0, 5);
      for (int j = 0; j < RL; j++)
         check($sformatf("t5.l%0d", j), cap_lane(b0, j), exp_lane(5, 0, j));

      // Asynchronous reset in the middle of a fill
      for (int k = 0; k < 10; k++) push(dval(k));
      b0 = nblk;
      start_msg(10, "t6");
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t6.busy", busy, 1'b0);
      check("t6.done", done, 1'b0);
      check("t6.rd_en", fifo_rd_en, 1'b0);
      check("t6.blk_valid", blk_valid, 1'b0);
      check("t6.blk_last", blk_last, 1'b0);
      check("t6.blk_data", (blk_data == '0), 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      wr_p = rd_p;
      check("t6.no_partial_block", nblk - b0, 0);
      run_msg(1, 1, 64'h8000_0000_0000_0000, "t6post");

      check("global.illegal_pops", bad_rd, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
